// File: rtl/falu_ieee_writeback_if.sv
// ---------------------------------------------------------------------------
// falu_ieee_writeback_if
//   Result bus between the FALU adder datapath and FP register writeback.
//   Input side : in_valid/in_ready handshake, in_data (internal format),
//                in_is_dbl, in_flags {NV,DZ,OF,UF,NX}, in_tag.
//   Output side: out_valid/out_ready handshake, out_data (IEEE binary64 or
//                NaN-boxed binary32), out_flags, out_tag.
//   Sticky flags: fflags_clr (CSR write), fflags_acc (accumulated flags).
//   Modports: master = producer/consumer environment, slave = writeback block.
// ---------------------------------------------------------------------------
interface falu_ieee_writeback_if #(
   parameter int unsigned TAG_W = 6
);
   logic             in_valid;
   logic             in_ready;
   logic [65:0]      in_data;
   logic             in_is_dbl;
   logic [4:0]       in_flags;
   logic [TAG_W-1:0] in_tag;
   logic             out_valid;
   logic             out_ready;
   logic [63:0]      out_data;
   logic [4:0]       out_flags;
   logic [TAG_W-1:0] out_tag;
   logic             fflags_clr;
   logic [4:0]       fflags_acc;

   modport master (
      output in_valid, in_data, in_is_dbl, in_flags, in_tag, out_ready, fflags_clr,
      input  in_ready, out_valid, out_data, out_flags, out_tag, fflags_acc
   );

   modport slave (
      input  in_valid, in_data, in_is_dbl, in_flags, in_tag, out_ready, fflags_clr,
      output in_ready, out_valid, out_data, out_flags, out_tag, fflags_acc
   );
endinterface

// File: rtl/falu_ieee_writeback.sv
// ---------------------------------------------------------------------------
// falu_ieee_writeback
//   Packs FALU results ({exc[1:0],sign,exp,frac}, exc 00=zero 01=normal
//   10=inf 11=NaN) into IEEE-754 binary64 register values; SP results are
//   NaN-boxed. Two-stage valid/ready pipeline (S1 = captured/decoded input,
//   S2 = packed output register) plus a sticky fflags accumulator.
//   Ports:
//     clk_i   - clock, rising edge
//     rst_ni  - asynchronous active-low reset
//     flush_i - synchronous squash of all in-flight entries
//     bus     - falu_ieee_writeback_if.slave (handshakes, data, flags, tag)
// ---------------------------------------------------------------------------
module falu_ieee_writeback #(
   parameter int unsigned TAG_W = 6
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  flush_i,
   falu_ieee_writeback_if.slave  bus
);

   // Ready is held low while in reset and rises on the first edge after release.
   logic             rdy_en_q;

   logic             s1_valid_q;
   logic [1:0]       s1_exc_q;
   logic             s1_dbl_q;
   logic [63:0]      s1_word_q;
   logic [4:0]       s1_flags_q;
   logic [TAG_W-1:0] s1_tag_q;

   logic             s2_valid_q;
   logic [63:0]      s2_data_q;
   logic [4:0]       s2_flags_q;
   logic [TAG_W-1:0] s2_tag_q;

   logic [4:0]       acc_q;

   logic             s2_can_load;
   logic             s1_can_load;
   logic             in_ready;
   logic             in_fire;
   logic             out_fire;
   logic [1:0]       in_exc;
   logic [63:0]      in_word;
   logic [63:0]      packed_d;

   // S2 frees up in the same cycle it transfers out, so the input side can
   // keep streaming at one result per cycle (bubble collapsing).
   assign s2_can_load = !s2_valid_q || bus.out_ready;
   assign s1_can_load = !s1_valid_q || s2_can_load;
   assign in_ready    = rdy_en_q && !flush_i && s1_can_load;
   assign in_fire     = bus.in_valid && in_ready;
   assign out_fire    = s2_valid_q && bus.out_ready;

   // S1 capture: the exception class and the relevant payload word are
   // selected by format here; SP upper input bits [65:34] are never stored.
   assign in_exc  = bus.in_is_dbl ? bus.in_data[65:64] : bus.in_data[33:32];
   assign in_word = bus.in_is_dbl ? bus.in_data[63:0]  : {32'h0, bus.in_data[31:0]};

   always_comb begin
      packed_d = '0;
      if (s1_dbl_q) begin
         unique case (s1_exc_q)
            2'b00:   packed_d = {s1_word_q[63], 63'b0};
            2'b01:   packed_d = s1_word_q;
            2'b10:   packed_d = {s1_word_q[63], 11'h7FF, 52'b0};
            default: packed_d = 64'h7FF8_0000_0000_0000;
         endcase
      end else begin
         unique case (s1_exc_q)
            2'b00:   packed_d = {32'hFFFF_FFFF, s1_word_q[31], 31'b0};
            2'b01:   packed_d = {32'hFFFF_FFFF, s1_word_q[31:0]};
            2'b10:   packed_d = {32'hFFFF_FFFF, s1_word_q[31], 8'hFF, 23'b0};
            default: packed_d = 64'hFFFF_FFFF_7FC0_0000;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rdy_en_q   <= 1'b0;
         s1_valid_q <= 1'b0;
         s1_exc_q   <= '0;
         s1_dbl_q   <= 1'b0;
         s1_word_q  <= '0;
         s1_flags_q <= '0;
         s1_tag_q   <= '0;
         s2_valid_q <= 1'b0;
         s2_data_q  <= '0;
         s2_flags_q <= '0;
         s2_tag_q   <= '0;
         acc_q      <= '0;
      end else begin
         rdy_en_q <= 1'b1;

         if (flush_i) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
         end else begin
            if (s2_can_load) s2_valid_q <= s1_valid_q;
            if (s1_can_load) s1_valid_q <= in_fire;
         end

         if (s2_can_load && s1_valid_q) begin
            s2_data_q  <= packed_d;
            s2_flags_q <= s1_flags_q;
            s2_tag_q   <= s1_tag_q;
         end

         if (in_fire) begin
            s1_exc_q   <= in_exc;
            s1_dbl_q   <= bus.in_is_dbl;
            s1_word_q  <= in_word;
            s1_flags_q <= bus.in_flags;
            s1_tag_q   <= bus.in_tag;
         end

         // Clear takes effect before the same-cycle transfer accumulates.
         if (bus.fflags_clr)
            acc_q <= out_fire ? s2_flags_q : 5'b0;
         else if (out_fire)
            acc_q <= acc_q | s2_flags_q;
      end
   end

   assign bus.in_ready   = in_ready;
   assign bus.out_valid  = s2_valid_q;
   assign bus.out_data   = s2_data_q;
   assign bus.out_flags  = s2_flags_q;
   assign bus.out_tag    = s2_tag_q;
   assign bus.fflags_acc = acc_q;

endmodule

// File: tb/tb_falu_ieee_writeback.sv
module tb_falu_ieee_writeback;
   localparam int unsigned TW = 6;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic flush = 1'b0;

   falu_ieee_writeback_if #(.TAG_W(TW)) bus ();

   falu_ieee_writeback #(.TAG_W(TW)) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .flush_i(flush),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Reference packing from the format rules, using masks on the raw word.
   function automatic logic [63:0] ref_pack(input logic [65:0] d, input logic dbl);
      logic [1:0]  c;
      logic [31:0] w;
      logic [63:0] r;
      if (dbl) begin
         c = d[65:64];
         if (c == 2'd0)      r = d[63:0] & 64'h8000_0000_0000_0000;
         else if (c == 2'd1) r = d[63:0];
         else if (c == 2'd2) r = (d[63:0] & 64'h8000_0000_0000_0000) | 64'h7FF0_0000_0000_0000;
         else                r = 64'h7FF8_0000_0000_0000;
      end else begin
         c = d[33:32];
         if (c == 2'd0)      w = d[31:0] & 32'h8000_0000;
         else if (c == 2'd1) w = d[31:0];
         else if (c == 2'd2) w = (d[31:0] & 32'h8000_0000) | 32'h7F80_0000;
         else                w = 32'h7FC0_0000;
         r = {32'hFFFF_FFFF, w};
      end
      return r;
   endfunction

   typedef struct {
      logic [65:0] d;
      logic        dbl;
      logic [63:0] exp;
   } vec_t;

   typedef struct {
      logic [63:0]    d;
      logic [4:0]     f;
      logic [TW-1:0]  t;
   } ent_t;

   vec_t vt[9];
   ent_t q[$];

   task automatic idle();
      bus.in_valid   = 1'b0;
      bus.in_data    = '0;
      bus.in_is_dbl  = 1'b0;
      bus.in_flags   = '0;
      bus.in_tag     = '0;
      bus.out_ready  = 1'b0;
      bus.fflags_clr = 1'b0;
   endtask

   // One isolated transaction with the consumer always ready; checks the
   // N+2 latency and the one-cycle OUT_VALID pulse.
   task automatic send_one(input string nm, input logic [65:0] d, input logic dbl,
                           input logic [4:0] f, input logic [TW-1:0] t, input logic [63:0] exp);
      @(negedge clk);
      bus.in_valid = 1'b1; bus.in_data = d; bus.in_is_dbl = dbl;
      bus.in_flags = f; bus.in_tag = t; bus.out_ready = 1'b1;
      #1 chk({nm, " in_ready"}, 64'(bus.in_ready), 64'd1);
      @(negedge clk);
      bus.in_valid = 1'b0;
      #1 chk({nm, " valid N+1"}, 64'(bus.out_valid), 64'd0);
      @(negedge clk);
      #1 chk({nm, " valid N+2"}, 64'(bus.out_valid), 64'd1);
      chk({nm, " data"}, bus.out_data, exp);
      chk({nm, " flags"}, 64'(bus.out_flags), 64'(f));
      chk({nm, " tag"}, 64'(bus.out_tag), 64'(t));
      @(negedge clk);
      #1 chk({nm, " valid pulse end"}, 64'(bus.out_valid), 64'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int nxt;
      int got;
      int k;
      logic [4:0]  acc_m;
      logic [4:0]  acc_b;
      logic [65:0] rd;
      logic [4:0]  rf;
      logic [TW-1:0] rt;
      logic        rdbl;
      ent_t        e;

      vt[0] = '{{2'b01, 64'h3FF0_0000_0000_0000}, 1'b1, 64'h3FF0_0000_0000_0000};
      vt[1] = '{{32'hDEAD_BEEF, 2'b11, 32'hFFA0_0000}, 1'b0, 64'hFFFF_FFFF_7FC0_0000};
      vt[2] = '{{2'b10, 1'b1, 63'h0000_0000_0012_3456}, 1'b1, 64'hFFF0_0000_0000_0000};
      vt[3] = '{{2'b00, 1'b1, 63'h0765_4321_ABCD_0001}, 1'b1, 64'h8000_0000_0000_0000};
      vt[4] = '{{32'h1234_5678, 2'b10, 32'h0000_0000}, 1'b0, 64'hFFFF_FFFF_7F80_0000};
      vt[5] = '{{2'b11, 64'h8000_0000_0000_0001}, 1'b1, 64'h7FF8_0000_0000_0000};
      vt[6] = '{{32'hFFFF_FFFF, 2'b01, 32'hC049_0FDB}, 1'b0, 64'hFFFF_FFFF_C049_0FDB};
      vt[7] = '{{32'h0000_0000, 2'b00, 32'h8000_1234}, 1'b0, 64'hFFFF_FFFF_8000_0000};
      vt[8] = '{{2'b01, 64'h800F_FFFF_FFFF_FFFF}, 1'b1, 64'h800F_FFFF_FFFF_FFFF};

      idle();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1;
      chk("reset out_valid", 64'(bus.out_valid), 64'd0);
      chk("reset out_data", bus.out_data, 64'd0);
      chk("reset out_flags", 64'(bus.out_flags), 64'd0);
      chk("reset out_tag", 64'(bus.out_tag), 64'd0);
      chk("reset acc", 64'(bus.fflags_acc), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      #1 chk("ready after reset", 64'(bus.in_ready), 64'd1);

      // Packing vectors
      for (int i = 0; i < 9; i++)
         send_one($sformatf("vec%0d", i), vt[i].d, vt[i].dbl, 5'(i), TW'(i + 1), vt[i].exp);

      // Backpressure: consumer stalled for 5 cycles, tags 1..4 offered back to back
      @(negedge clk);
      bus.out_ready = 1'b0;
      nxt = 1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         bus.in_valid = (nxt <= 4); bus.in_tag = TW'(nxt); bus.in_is_dbl = 1'b1;
         bus.in_data = {2'b01, 64'h4000_0000_0000_0000 | 64'(nxt)}; bus.in_flags = 5'(nxt);
         #1;
         if (c >= 2) begin
            chk("stall valid", 64'(bus.out_valid), 64'd1);
            chk("stall tag", 64'(bus.out_tag), 64'd1);
            chk("stall data", bus.out_data, 64'h4000_0000_0000_0001);
         end
         if (bus.in_valid && bus.in_ready) nxt++;
      end
      chk("accepted under stall", 64'(nxt - 1), 64'd2);
      got = 0;
      for (int c = 0; c < 20 && got < 4; c++) begin
         @(negedge clk);
         bus.out_ready = 1'b1;
         bus.in_valid = (nxt <= 4); bus.in_tag = TW'(nxt);
         bus.in_data = {2'b01, 64'h4000_0000_0000_0000 | 64'(nxt)}; bus.in_flags = 5'(nxt);
         #1;
         if (bus.out_valid) begin
            chk("order tag", 64'(bus.out_tag), 64'(got + 1));
            got++;
         end
         if (bus.in_valid && bus.in_ready) nxt++;
      end
      chk("drained count", 64'(got), 64'd4);
      @(negedge clk);
      bus.in_valid = 1'b0;
      @(negedge clk);
      #1 chk("no duplicate", 64'(bus.out_valid), 64'd0);

      // Sticky flags
      @(negedge clk); bus.fflags_clr = 1'b1;
      @(negedge clk); bus.fflags_clr = 1'b0;
      #1 chk("clr alone 1", 64'(bus.fflags_acc), 64'd0);
      send_one("flagA", vt[0].d, 1'b1, 5'b00001, 6'd7, vt[0].exp);
      send_one("flagB", vt[0].d, 1'b1, 5'b00100, 6'd8, vt[0].exp);
      chk("acc or", 64'(bus.fflags_acc), 64'b00101);
      @(negedge clk);
      bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.in_flags = 5'b10000; bus.in_tag = 6'd9;
      @(negedge clk);
      bus.in_valid = 1'b0;
      k = 0;
      #1;
      while (!bus.out_valid && k < 10) begin
         @(negedge clk); #1; k++;
      end
      chk("clr+xfer valid", 64'(bus.out_valid), 64'd1);
      bus.out_ready = 1'b1; bus.fflags_clr = 1'b1;
      @(negedge clk);
      bus.fflags_clr = 1'b0;
      #1 chk("clr+xfer acc", 64'(bus.fflags_acc), 64'b10000);
      @(negedge clk); bus.fflags_clr = 1'b1;
      @(negedge clk); bus.fflags_clr = 1'b0;
      #1 chk("clr alone 2", 64'(bus.fflags_acc), 64'd0);

      // Flush with two entries held
      send_one("preflush", vt[6].d, 1'b0, 5'b00010, 6'd20, vt[6].exp);
      @(negedge clk);
      bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.in_tag = 6'd10; bus.in_flags = 5'b11111;
      @(negedge clk); bus.in_tag = 6'd11;
      @(negedge clk); bus.in_valid = 1'b0;
      #1 chk("full ready", 64'(bus.in_ready), 64'd0);
      acc_b = bus.fflags_acc;
      @(negedge clk);
      flush = 1'b1; bus.in_valid = 1'b1; bus.in_tag = 6'd12;
      #1 chk("flush ready", 64'(bus.in_ready), 64'd0);
      @(negedge clk);
      flush = 1'b0; bus.in_valid = 1'b0;
      #1;
      chk("flush valid", 64'(bus.out_valid), 64'd0);
      chk("flush ready after", 64'(bus.in_ready), 64'd1);
      chk("flush acc", 64'(bus.fflags_acc), 64'(acc_b));
      bus.out_ready = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         #1 chk("flush dropped", 64'(bus.out_valid), 64'd0);
      end

      // Reset mid-stream
      @(negedge clk);
      bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.in_tag = 6'd33; bus.in_flags = 5'b01010;
      bus.in_data = vt[8].d; bus.in_is_dbl = 1'b1;
      @(negedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("rst valid", 64'(bus.out_valid), 64'd0);
      chk("rst data", bus.out_data, 64'd0);
      chk("rst flags", 64'(bus.out_flags), 64'd0);
      chk("rst tag", 64'(bus.out_tag), 64'd0);
      chk("rst acc", 64'(bus.fflags_acc), 64'd0);
      idle();
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Randomized traffic against the reference model
      acc_m = '0;
      q.delete();
      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         rd   = {2'($urandom), $urandom, $urandom};
         rdbl = 1'($urandom);
         rf   = 5'($urandom);
         rt   = TW'($urandom);
         bus.in_valid   = ($urandom_range(3) != 0);
         bus.in_data    = rd;
         bus.in_is_dbl  = rdbl;
         bus.in_flags   = rf;
         bus.in_tag     = rt;
         bus.out_ready  = ($urandom_range(2) != 0);
         bus.fflags_clr = ($urandom_range(15) == 0);
         #1;
         if (bus.out_valid && bus.out_ready) begin
            if (q.size() == 0) begin
               chk("rand spurious", 64'(bus.out_valid), 64'd0);
               if (bus.fflags_clr) acc_m = '0;
            end else begin
               e = q.pop_front();
               chk("rand data", bus.out_data, e.d);
               chk("rand flags", 64'(bus.out_flags), 64'(e.f));
               chk("rand tag", 64'(bus.out_tag), 64'(e.t));
               acc_m = bus.fflags_clr ? e.f : (acc_m | e.f);
            end
         end else if (bus.fflags_clr) begin
            acc_m = '0;
         end
         if (bus.in_valid && bus.in_ready)
            q.push_back('{ref_pack(rd, rdbl), rf, rt});
         @(posedge clk);
         #1 chk("rand acc", 64'(bus.fflags_acc), 64'(acc_m));
      end
      bus.in_valid = 1'b0; bus.fflags_clr = 1'b0; bus.out_ready = 1'b1;
      for (int c = 0; c < 10 && q.size() > 0; c++) begin
         @(negedge clk);
         #1;
         if (bus.out_valid) begin
            e = q.pop_front();
            chk("drain data", bus.out_data, e.d);
            chk("drain tag", 64'(bus.out_tag), 64'(e.t));
         end
      end
      chk("drain empty", 64'(q.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
